track_ram_scheduler: RTL and testbench
======================================

Name: track_ram_scheduler

Overview:
Shares one single-port beat RAM between track A and track B. Consumes the mode controls from the beat recorder FSM (play A/B/both, record A/B) and a sample tick. On each tick it services track A, then track B, issuing RAM writes for recording and RAM reads for playback. Per-track write/read pointers and recorded lengths give loop playback with wrap-around.

Parameters:
ADDR_W, 10, per-track address width; track depth = 2^ADDR_W words
DATA_W, 8, sample width (one bit per key/voice)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle pulse at the beat sample rate
play_a  in  1  loadAFromRam level from the mode FSM
play_b  in  1  loadBFromRam level
rec_a  in  1  ramARecord level
rec_b  in  1  ramBRecord level
rec_data  in  DATA_W  live key sample to record
ram_addr  out  ADDR_W+1  RAM address; MSB 0 = track A, 1 = track B
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
play_a_data  out  DATA_W  last sample played from A
play_b_data  out  DATA_W  last sample played from B
play_a_valid  out  1  one-cycle pulse when play_a_data updates
play_b_valid  out  1  one-cycle pulse when play_b_data updates
len_a  out  ADDR_W+1  recorded length of A (0..2^ADDR_W)
len_b  out  ADDR_W+1  recorded length of B
busy  out  1  high when state is not IDLE
overrun  out  1  sticky; tick arrived while busy

Behaviour:
- Reset: state IDLE; all outputs, pointers and lengths 0.
- States: IDLE -> SLOT_A -> WAIT_A -> SLOT_B -> WAIT_B -> IDLE. The transition from IDLE happens only on sample_tick; every other transition is unconditional.
- Timing: tick sampled at edge k. SLOT_A is cycle k+1 (address and we driven). WAIT_A is cycle k+2 (rdata captured). play_a_valid is high in cycle k+3. SLOT_B/WAIT_B follow in k+3/k+4, and play_b_valid is high in k+5. Minimum tick spacing is 5 cycles.
- Slot action per track X, using rec_x/play_x sampled in its SLOT cycle:
  - rec_x=1: ram_we=1, ram_addr={X,wr_ptr}, ram_wdata=rec_data. wr_ptr increments and len_x = wr_ptr+1. Record wins over play_x on the same track. No valid pulse.
  - else play_x=1 and len_x>0: read at {X,rd_ptr}. Capture rdata into play_x_data and pulse valid. rd_ptr = (rd_ptr+1 == len_x) ? 0 : rd_ptr+1.
  - else play_x=1 and len_x=0: play_x_data = 0 and pulse valid; no RAM access.
  - else: idle slot; ram_we=0 and ram_addr held.
- Full: when wr_ptr reaches 2^ADDR_W, further record slots are ignored (no write). len_x stays at 2^ADDR_W.
- Rising edge of rec_x (edge detect on clk): wr_ptr=0, len_x=0. Rising edge of play_x: rd_ptr=0. When an edge and a slot coincide, the edge reset is applied first.
- A sample_tick arriving while busy is dropped and sets overrun. Overrun clears only on reset.
- ram_we is high only in SLOT cycles, except under the optional feature.
- Reset mid-sequence returns to IDLE immediately; no partial write completes after resetn deasserts.

Optional Feature:
SCHED_OVERDUB_EN:
- Defined: when recording with wr_ptr < len_x, SLOT reads {X,wr_ptr}. WAIT then writes rdata | rec_data to the same address, with ram_we high in WAIT. A rising edge of rec_x clears wr_ptr only; len_x is kept, and len_x = max(len_x, wr_ptr+1). Beyond the existing length, writes are plain.
- Undefined: record always overwrites, and the rec_x edge clears len_x.

Decomposition:
- A shared package/include holds the state encoding (IDLE, SLOT_A, WAIT_A, SLOT_B, WAIT_B), the track-select constants TRACK_A=0 and TRACK_B=1, and default ADDR_W/DATA_W.
- Sub-module track_pointer, instantiated twice: wr_ptr, rd_ptr, len, edge detects, full flag and wrap logic for one track.

Test Plan:
- Reset then rec_a=1 with 3 ticks, rec_data=8'h01,02,04 -> writes at addresses 0,1,2 with ram_we in SLOT_A cycles; len_a=3.
- Then rec_a=0, play_a=1, 5 ticks -> play_a_data sequence 01,02,04,01,02; play_a_valid at k+3 after each tick.
- play_a=1 and play_b=1 with len_b=0 -> A reads at {0,ptr}; play_b_data=0 with play_b_valid at k+5; no B address issued.
- ADDR_W=2, record 6 ticks -> only 4 writes; len_a=4; ticks 5-6 produce no ram_we.
- Tick at k, second tick at k+2 -> overrun=1 and only one sequence runs; resetn pulse clears overrun and returns to IDLE.
- With SCHED_OVERDUB_EN: A holds 01,02; re-record with rec_data=8'h10 twice -> RAM holds 11,12 and len_a stays 2.

Source files
------------

// File: rtl/track_ram_scheduler_pkg.sv
// Shared definitions for the track RAM scheduler: slot states, track select bits, default widths.
// state | meaning: IDLE wait tick; SLOT_x drive RAM for track x; WAIT_x capture rdata / overdub write.
package track_ram_scheduler_pkg;

  localparam int SCHED_ADDR_W = 10;
  localparam int SCHED_DATA_W = 8;

  localparam logic TRACK_A = 1'b0;
  localparam logic TRACK_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SLOT_A = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_SLOT_B = 3'd3,
    ST_WAIT_B = 3'd4
  } sched_state_e;

endpackage

// File: rtl/track_ram_scheduler_track_pointer.sv
// Per-track write/read pointers, recorded length and level edge detects for one beat track.
// SCHED_OVERDUB_EN: recording inside the existing loop becomes read-modify-write and keeps the length.
module track_ram_scheduler_track_pointer
  import track_ram_scheduler_pkg::*;
#(
  parameter int ADDR_W = SCHED_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              slot_i,
  input  logic              rec_i,
  input  logic              play_i,
  output logic              write_o,
  output logic              odub_o,
  output logic              read_o,
  output logic              zero_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W:0]   len_o
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_q, wr_d, rd_q, rd_d, len_q, len_d;
  logic [ADDR_W:0] wr_eff, rd_eff, len_eff;
  logic            rec_prev_q, play_prev_q;
  logic            rec_rise, play_rise, full, in_loop;

  assign rec_rise  = rec_i & ~rec_prev_q;
  assign play_rise = play_i & ~play_prev_q;
  assign len_o     = len_q;

  // Edge resets are folded in before the slot decision so a coinciding slot sees them.
  always_comb begin
    wr_eff = rec_rise ? '0 : wr_q;
    rd_eff = play_rise ? '0 : rd_q;
`ifdef SCHED_OVERDUB_EN
    len_eff = len_q;
    in_loop = (wr_eff < len_eff);
`else
    len_eff = rec_rise ? '0 : len_q;
    in_loop = 1'b0;
`endif
    full    = wr_eff[ADDR_W];
    wr_d    = wr_eff;
    rd_d    = rd_eff;
    len_d   = len_eff;
    write_o = 1'b0;
    odub_o  = 1'b0;
    read_o  = 1'b0;
    zero_o  = 1'b0;
    addr_o  = '0;
    if (slot_i) begin
      if (rec_i) begin
        if (!full) begin
          addr_o = wr_eff[ADDR_W-1:0];
          wr_d   = wr_eff + ONE;
          if (in_loop) begin
            odub_o = 1'b1;
          end else begin
            write_o = 1'b1;
            len_d   = wr_eff + ONE;
          end
        end
      end else if (play_i) begin
        if (len_eff != '0) begin
          read_o = 1'b1;
          addr_o = rd_eff[ADDR_W-1:0];
          rd_d   = ((rd_eff + ONE) >= len_eff) ? '0 : rd_eff + ONE;
        end else begin
          zero_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q        <= '0;
      rd_q        <= '0;
      len_q       <= '0;
      rec_prev_q  <= 1'b0;
      play_prev_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      len_q       <= len_d;
      rec_prev_q  <= rec_i;
      play_prev_q <= play_i;
    end
  end

endmodule

// File: rtl/track_ram_scheduler.sv
// Time-multiplexes one single-port beat RAM between track A and track B on every sample tick.
// Optional overdub (OR new keys into the existing loop) is enabled by defining SCHED_OVERDUB_EN.
module track_ram_scheduler
  import track_ram_scheduler_pkg::*;
#(
  parameter int ADDR_W = SCHED_ADDR_W,
  parameter int DATA_W = SCHED_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_tick,
  input  logic              play_a,
  input  logic              play_b,
  input  logic              rec_a,
  input  logic              rec_b,
  input  logic [DATA_W-1:0] rec_data,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] play_a_data,
  output logic [DATA_W-1:0] play_b_data,
  output logic              play_a_valid,
  output logic              play_b_valid,
  output logic [ADDR_W:0]   len_a,
  output logic [ADDR_W:0]   len_b,
  output logic              busy,
  output logic              overrun
);

  sched_state_e      state_q, state_d;
  logic              slot_a, slot_b;
  logic              a_write, a_odub, a_read, a_zero;
  logic              b_write, b_odub, b_read, b_zero;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              pend_read_q, pend_read_d, pend_zero_q, pend_zero_d, pend_odub_q, pend_odub_d;
  logic [DATA_W-1:0] odub_data_q, odub_data_d;
  logic [ADDR_W:0]   addr_q;
  logic [DATA_W-1:0] play_a_data_q, play_b_data_q;
  logic              play_a_valid_q, play_b_valid_q, overrun_q;

  assign slot_a       = (state_q == ST_SLOT_A);
  assign slot_b       = (state_q == ST_SLOT_B);
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;
  assign play_a_data  = play_a_data_q;
  assign play_b_data  = play_b_data_q;
  assign play_a_valid = play_a_valid_q;
  assign play_b_valid = play_b_valid_q;

  track_ram_scheduler_track_pointer #(.ADDR_W(ADDR_W)) u_track_a (
    .clk(clk), .resetn(resetn), .slot_i(slot_a), .rec_i(rec_a), .play_i(play_a),
    .write_o(a_write), .odub_o(a_odub), .read_o(a_read), .zero_o(a_zero),
    .addr_o(a_addr), .len_o(len_a)
  );

  track_ram_scheduler_track_pointer #(.ADDR_W(ADDR_W)) u_track_b (
    .clk(clk), .resetn(resetn), .slot_i(slot_b), .rec_i(rec_b), .play_i(play_b),
    .write_o(b_write), .odub_o(b_odub), .read_o(b_read), .zero_o(b_zero),
    .addr_o(b_addr), .len_o(len_b)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sample_tick) state_d = ST_SLOT_A;
      ST_SLOT_A: state_d = ST_WAIT_A;
      ST_WAIT_A: state_d = ST_SLOT_B;
      ST_SLOT_B: state_d = ST_WAIT_B;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ram_addr holds its last value whenever a cycle issues no access.
  always_comb begin
    ram_addr    = addr_q;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    pend_read_d = 1'b0;
    pend_zero_d = 1'b0;
    pend_odub_d = 1'b0;
    odub_data_d = odub_data_q;
    if (slot_a) begin
      pend_read_d = a_read;
      pend_zero_d = a_zero;
      pend_odub_d = a_odub;
      odub_data_d = rec_data;
      if (a_write || a_odub || a_read) ram_addr = {TRACK_A, a_addr};
      if (a_write) begin
        ram_we    = 1'b1;
        ram_wdata = rec_data;
      end
    end else if (slot_b) begin
      pend_read_d = b_read;
      pend_zero_d = b_zero;
      pend_odub_d = b_odub;
      odub_data_d = rec_data;
      if (b_write || b_odub || b_read) ram_addr = {TRACK_B, b_addr};
      if (b_write) begin
        ram_we    = 1'b1;
        ram_wdata = rec_data;
      end
    end else if (pend_odub_q) begin
      ram_we    = 1'b1;
      ram_wdata = ram_rdata | odub_data_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      pend_read_q    <= 1'b0;
      pend_zero_q    <= 1'b0;
      pend_odub_q    <= 1'b0;
      odub_data_q    <= '0;
      play_a_data_q  <= '0;
      play_b_data_q  <= '0;
      play_a_valid_q <= 1'b0;
      play_b_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= ram_addr;
      pend_read_q    <= pend_read_d;
      pend_zero_q    <= pend_zero_d;
      pend_odub_q    <= pend_odub_d;
      odub_data_q    <= odub_data_d;
      play_a_valid_q <= (state_q == ST_WAIT_A) && (pend_read_q || pend_zero_q);
      play_b_valid_q <= (state_q == ST_WAIT_B) && (pend_read_q || pend_zero_q);
      if (state_q == ST_WAIT_A && pend_read_q) play_a_data_q <= ram_rdata;
      else if (state_q == ST_WAIT_A && pend_zero_q) play_a_data_q <= '0;
      if (state_q == ST_WAIT_B && pend_read_q) play_b_data_q <= ram_rdata;
      else if (state_q == ST_WAIT_B && pend_zero_q) play_b_data_q <= '0;
      if (sample_tick && state_q != ST_IDLE) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_track_ram_scheduler.sv
// Bench for track_ram_scheduler: directed vector table, overrun/reset sequences and random traffic
// checked every cycle against a slot-level reference model of both tracks and the RAM image.
module tb_track_ram_scheduler;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef SCHED_OVERDUB_EN
  localparam bit OD = 1'b1;
  localparam int L10 = 3, L11 = 3, L12 = 3;
  localparam logic [7:0] P16 = 8'h09, P17 = 8'h12, P18 = 8'h24;
`else
  localparam bit OD = 1'b0;
  localparam int L10 = 1, L11 = 2, L12 = 3;
  localparam logic [7:0] P16 = 8'h08, P17 = 8'h10, P18 = 8'h20;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sample_tick = 1'b0;
  logic          play_a = 1'b0, play_b = 1'b0, rec_a = 1'b0, rec_b = 1'b0;
  logic [DW-1:0] rec_data = '0;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] play_a_data, play_b_data;
  logic          play_a_valid, play_b_valid;
  logic [AW:0]   len_a, len_b;
  logic          busy, overrun;

  always #5 clk = ~clk;

  track_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn), .sample_tick(sample_tick),
    .play_a(play_a), .play_b(play_b), .rec_a(rec_a), .rec_b(rec_b), .rec_data(rec_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .play_a_data(play_a_data), .play_b_data(play_b_data),
    .play_a_valid(play_a_valid), .play_b_valid(play_b_valid),
    .len_a(len_a), .len_b(len_b), .busy(busy), .overrun(overrun)
  );

  logic [DW-1:0] ram [2*DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Reference model: per-track pointers/lengths, expected RAM image and slot position.
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int            m_wr [2], m_len [2], m_rd [2];
  bit            m_prev_rec [2], m_prev_play [2];
  logic [DW-1:0] m_mem [2*DEPTH];
  int            m_pos, m_addr_hold;
  bit            m_ovr;
  logic [DW-1:0] m_pdata [2], m_vdata [2];
  int            m_vcyc [2];
  bit            m_od_pend;
  int            m_od_addr;
  logic [DW-1:0] m_od_data;

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_wr[t] = 0; m_len[t] = 0; m_rd[t] = 0;
      m_prev_rec[t] = 1'b0; m_prev_play[t] = 1'b0;
      m_pdata[t] = '0; m_vdata[t] = '0; m_vcyc[t] = -1;
    end
    m_pos = -1; m_addr_hold = 0; m_ovr = 1'b0; m_od_pend = 1'b0; m_od_addr = 0; m_od_data = '0;
  endtask

  always @(negedge clk) begin : model
    logic          rec_l [2];
    logic          play_l [2];
    int            x, a, exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wd;
    bit            busy_now;
    cyc++;
    if (chk_en && resetn) begin
      rec_l[0] = rec_a; rec_l[1] = rec_b; play_l[0] = play_a; play_l[1] = play_b;
      for (int t = 0; t < 2; t++) if (m_vcyc[t] == cyc) m_pdata[t] = m_vdata[t];
      check("busy", busy, m_pos >= 0);
      check("overrun", overrun, m_ovr);
      check("len_a", len_a, m_len[0]);
      check("len_b", len_b, m_len[1]);
      check("valid_a", play_a_valid, m_vcyc[0] == cyc);
      check("valid_b", play_b_valid, m_vcyc[1] == cyc);
      check("data_a", play_a_data, m_pdata[0]);
      check("data_b", play_b_data, m_pdata[1]);
      for (int t = 0; t < 2; t++) begin
        if (rec_l[t] && !m_prev_rec[t]) begin
          m_wr[t] = 0;
          if (!OD) m_len[t] = 0;
        end
        if (play_l[t] && !m_prev_play[t]) m_rd[t] = 0;
        m_prev_rec[t] = rec_l[t];
        m_prev_play[t] = play_l[t];
      end
      exp_we = 1'b0; exp_addr = m_addr_hold; exp_wd = '0;
      if (m_pos == 0 || m_pos == 2) begin
        x = m_pos / 2;
        a = x * DEPTH;
        if (rec_l[x]) begin
          if (m_wr[x] < DEPTH) begin
            a += m_wr[x];
            exp_addr = a;
            if (OD && m_wr[x] < m_len[x]) begin
              m_od_pend = 1'b1; m_od_addr = a; m_od_data = rec_data;
            end else begin
              exp_we = 1'b1; exp_wd = rec_data; m_mem[a] = rec_data;
              m_len[x] = (m_wr[x] + 1 > m_len[x]) ? m_wr[x] + 1 : m_len[x];
            end
            m_wr[x]++;
          end
        end else if (play_l[x]) begin
          if (m_len[x] > 0) begin
            a += m_rd[x];
            exp_addr = a;
            m_vdata[x] = m_mem[a];
            m_rd[x] = (m_rd[x] + 1 >= m_len[x]) ? 0 : m_rd[x] + 1;
          end else begin
            m_vdata[x] = '0;
          end
          m_vcyc[x] = cyc + 2;
        end
      end else if (m_od_pend) begin
        exp_we = 1'b1; exp_addr = m_od_addr;
        exp_wd = m_mem[m_od_addr] | m_od_data;
        m_mem[m_od_addr] = exp_wd;
        m_od_pend = 1'b0;
      end
      check("ram_we", ram_we, exp_we);
      check("ram_addr", ram_addr, exp_addr);
      if (exp_we) check("ram_wdata", ram_wdata, exp_wd);
      m_addr_hold = exp_addr;
      busy_now = (m_pos >= 0);
      if (sample_tick && busy_now) m_ovr = 1'b1;
      if (busy_now) m_pos = (m_pos == 3) ? -1 : m_pos + 1;
      else if (sample_tick) m_pos = 0;
    end
  end

  typedef struct {
    bit            ra, pa, rb, pb;
    logic [7:0]    d;
    int            la, lb;
    logic [7:0]    pad, pbd;
  } vec_t;

  function automatic vec_t mk(input bit ra, pa, rb, pb, input logic [7:0] d,
                              input int la, lb, input logic [7:0] pad, pbd);
    vec_t v;
    v.ra = ra; v.pa = pa; v.rb = rb; v.pb = pb; v.d = d;
    v.la = la; v.lb = lb; v.pad = pad; v.pbd = pbd;
    return v;
  endfunction

  vec_t tbl [21];
  int   nb;

  initial begin
    for (int i = 0; i < 2*DEPTH; i++) begin ram[i] = '0; m_mem[i] = '0; end
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1, 0, 8'h00, 8'h00);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 2, 0, 8'h00, 8'h00);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 3, 0, 8'h00, 8'h00);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 8'h01, 8'h00);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 8'h02, 8'h00);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 8'h04, 8'h00);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 8'h01, 8'h00);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 0, 8'h02, 8'h00);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3, 0, 8'h04, 8'h00);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, L10, 0, 8'h04, 8'h00);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, L11, 0, 8'h04, 8'h00);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, L12, 0, 8'h04, 8'h00);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 4, 0, 8'h04, 8'h00);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 4, 0, 8'h04, 8'h00);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 4, 0, 8'h04, 8'h00);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4, 0, P16, 8'h00);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4, 0, P17, 8'h00);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4, 0, P18, 8'h00);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 4, 1, P18, 8'h00);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4, 1, P18, 8'h33);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4, 1, P18, 8'h33);

    model_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_we", ram_we, 0);
    check("rst_len_a", len_a, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      rec_a = tbl[i].ra; play_a = tbl[i].pa; rec_b = tbl[i].rb; play_b = tbl[i].pb;
      rec_data = tbl[i].d; sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("vec%0d_len_a", i), len_a, tbl[i].la);
      check($sformatf("vec%0d_len_b", i), len_b, tbl[i].lb);
      check($sformatf("vec%0d_play_a", i), play_a_data, tbl[i].pad);
      check($sformatf("vec%0d_play_b", i), play_b_data, tbl[i].pbd);
    end

    // second tick two cycles after the first must be dropped
    @(posedge clk); #1;
    rec_a = 1'b0; play_a = 1'b0; rec_b = 1'b0; play_b = 1'b0; sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0; nb = int'(busy);
    @(posedge clk); #1 sample_tick = 1'b1; nb += int'(busy);
    @(posedge clk); #1 sample_tick = 1'b0; nb += int'(busy);
    repeat (6) begin @(posedge clk); #1 nb += int'(busy); end
    check("ovr_busy_cycles", nb, 4);
    check("ovr_set", overrun, 1);

    // reset in the middle of a record slot
    @(posedge clk); #1;
    rec_a = 1'b1; rec_data = 8'h5A; sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    check("slot_we_before_rst", ram_we, 1);
    resetn = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_we", ram_we, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_len_a", len_a, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    repeat (3000) begin
      @(posedge clk); #1;
      sample_tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) rec_a = ~rec_a;
      if ($urandom_range(0, 15) == 0) rec_b = ~rec_b;
      if ($urandom_range(0, 15) == 0) play_a = ~play_a;
      if ($urandom_range(0, 15) == 0) play_b = ~play_b;
      rec_data = 8'($urandom);
    end
    @(posedge clk); #1;
    sample_tick = 1'b0; rec_a = 1'b0; rec_b = 1'b0; play_a = 1'b0; play_b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
